xspi_txn_scheduler: RTL
=======================

# xspi_txn_scheduler

Transaction scheduler in front of the xSPI master engine. It accepts read/write requests from NREQ requesters and grants them round-robin, one at a time. It issues each granted request to the engine and retries it on CRC error up to a programmable limit. It returns a single response per request: data plus status. It owns the retry policy that the engine and slave otherwise only flag.

## Interface
- NREQ, 2: number of requesters (2..8)
- MAX_RETRY, 3: retransmissions allowed after the first attempt (1..7)
- TIMEOUT, 255: cycles allowed from eng_start to eng_done before abort (≥16)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request pending, per requester
- req_ready  out  NREQ  one-hot grant; handshake = req_valid & req_ready
- req_write  in  NREQ  1 = write (cmd 8'hA5), 0 = read (cmd 8'hFF)
- req_addr  in  NREQ*48  address, requester i at [48i+47:48i]
- req_wdata  in  NREQ*64  write data, requester i at [64i+63:64i]
- rsp_valid  out  NREQ  one-cycle response pulse to the owning requester
- rsp_rdata  out  64  read data; 0 for writes and failures
- rsp_status  out  2  00 ok, 01 CRC fail after retries, 10 timeout
- eng_start  out  1  one-cycle pulse launching a transfer
- eng_cmd  out  8  command byte, stable from grant to response
- eng_addr  out  48  address, stable likewise
- eng_wdata  out  64  write data, stable likewise
- eng_busy  in  1  engine cannot accept eng_start
- eng_done  in  1  one-cycle pulse, transfer finished
- eng_crc_err  in  1  CA or data CRC error, sampled only with eng_done
- eng_rdata  in  64  read data, sampled only with eng_done
- retry_cnt  out  3  retries consumed by the current request
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**: if any req_valid is set, req_ready is asserted combinationally, one-hot, for the winner. The winner is the first valid index at or after rr_ptr, searching upward and wrapping.
  - On handshake: latch index, cmd, addr, wdata; clear retry_cnt; go to ISSUE.
  - With no valid request, req_ready = 0.
- **ISSUE**: if eng_busy = 0, pulse eng_start, clear the timer, go to WAIT. Otherwise hold in ISSUE without pulsing.
- **WAIT**: the timer increments every cycle. On eng_done:
  - eng_crc_err = 0: status 00; rdata = eng_rdata for reads, 0 for writes; go to RESP.
  - eng_crc_err = 1 and retry_cnt < MAX_RETRY: retry_cnt++; go to ISSUE; cmd, addr and wdata are unchanged.
  - eng_crc_err = 1 and retry_cnt = MAX_RETRY: status 01, rdata 0, go to RESP.
  - If the timer reaches TIMEOUT with no eng_done: status 10, rdata 0, go to RESP. A timeout is never retried.
- **RESP**: pulse rsp_valid[index] for one cycle. rr_ptr = (index+1) mod NREQ. Go to IDLE.
- rsp_rdata and rsp_status hold their value until the next RESP.
- Requesters cannot back-pressure responses.

## Timing
- Handshake at cycle T. eng_start at T+1 if not busy.
- Response at D+1, where D is the eng_done cycle of the last attempt.
- Best case: request to response = 2 + engine latency.
- Back-to-back operation: a new grant is possible in the cycle after RESP.
- eng_done and timer = TIMEOUT in the same cycle: done wins.
- eng_done in IDLE, ISSUE or RESP: ignored.
- A requester dropping req_valid before handshake: no grant, nothing latched.
- Reset values:
  - req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_status 00.
  - eng_start 0, eng_cmd 8'h00, eng_addr 0, eng_wdata 0.
  - retry_cnt 0, busy 0, rr_ptr 0, state IDLE.
- Reset mid-transfer abandons the request with no response; the engine shares rst_n.

## Structure
- Shared package xspi_pkg:
  - opcodes CMD_WRITE = 8'hA5, CMD_READ = 8'hFF;
  - status codes ST_OK, ST_CRC_FAIL, ST_TIMEOUT;
  - scheduler state enum.
- Sub-module xspi_rr_arbiter: combinational one-hot round-robin pick from the req_valid vector and rr_ptr; also outputs the winner index.
- Scheduler top contains the FSM, the request/response registers, the timer and the retry counter.

## Test plan
- Req0 write addr 0x0000_0000_0010, data 0x1122334455667788, clean engine → one eng_start, eng_cmd A5; rsp_valid[0] one cycle after eng_done; status 00, rdata 0.
- Req0 and req1 valid together, rr_ptr 0 → req0 granted first, then req1. With both again valid: req0 then req1 ordering continues alternating after each RESP.
- Read where the engine returns eng_crc_err = 1 twice, then clean with rdata 0xDEADBEEFCAFEF00D → 3 eng_start pulses, retry_cnt reaches 2, status 00, rsp_rdata DEADBEEFCAFEF00D.
- eng_crc_err = 1 on every attempt, MAX_RETRY = 3 → exactly 4 eng_start pulses, status 01, rdata 0.
- No eng_done → response TIMEOUT+1 cycles after eng_start, status 10, single eng_start. eng_done and timeout in the same cycle → status 00.
- eng_busy held high 5 cycles after grant → eng_start delayed to the first non-busy cycle. rst_n asserted in WAIT → all outputs zero immediately, no rsp_valid.

Source files
------------

// File: rtl/xspi_pkg.sv
// Shared definitions for the xSPI transaction scheduler: opcodes, response status codes
// and the scheduler state encoding.
package xspi_pkg;

   localparam logic [7:0] CMD_WRITE = 8'hA5;
   localparam logic [7:0] CMD_READ  = 8'hFF;

   localparam logic [1:0] ST_OK       = 2'b00;
   localparam logic [1:0] ST_CRC_FAIL = 2'b01;
   localparam logic [1:0] ST_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } sched_state_e;

   function automatic logic [7:0] cmd_of(input logic write);
      return write ? CMD_WRITE : CMD_READ;
   endfunction

endpackage

// File: rtl/xspi_txn_scheduler_if.sv
// Requester and engine signals of the transaction scheduler. The master modport is the
// scheduler's view; the slave modport is the requesters plus the xSPI engine.
interface xspi_txn_scheduler_if #(
   parameter int unsigned NREQ = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    req_write;
   logic [NREQ*48-1:0] req_addr;
   logic [NREQ*64-1:0] req_wdata;
   logic [NREQ-1:0]    rsp_valid;
   logic [63:0]        rsp_rdata;
   logic [1:0]         rsp_status;
   logic               eng_start;
   logic [7:0]         eng_cmd;
   logic [47:0]        eng_addr;
   logic [63:0]        eng_wdata;
   logic               eng_busy;
   logic               eng_done;
   logic               eng_crc_err;
   logic [63:0]        eng_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      input  eng_busy, eng_done, eng_crc_err, eng_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_status,
      output eng_start, eng_cmd, eng_addr, eng_wdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      output eng_busy, eng_done, eng_crc_err, eng_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_status,
      input  eng_start, eng_cmd, eng_addr, eng_wdata
   );

endinterface

// File: rtl/xspi_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping upward.
// Produces a one-hot grant and the winner index.
module xspi_rr_arbiter #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] pos;
   logic             found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         pos = IDX_W'((32'(ptr) + i) % NREQ);
         if (!found && valid[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/xspi_txn_scheduler.sv
// Grants requests round-robin, issues them to the xSPI engine, retries on CRC error up to
// MAX_RETRY times, aborts on timeout, and returns one response per request.
module xspi_txn_scheduler
   import xspi_pkg::*;
#(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned MAX_RETRY = 3,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   xspi_txn_scheduler_if.master bus,
   output logic [2:0]           retry_cnt,
   output logic                 busy
);

   localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   sched_state_e     state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, idx_q, idx_d, win_idx;
   logic [NREQ-1:0]  grant;
   logic [7:0]       cmd_q, cmd_d;
   logic [47:0]      addr_q, addr_d;
   logic [63:0]      wdata_q, wdata_d, rdata_q, rdata_d;
   logic [1:0]       status_q, status_d;
   logic [2:0]       retry_q, retry_d;
   logic [TMR_W-1:0] timer_q, timer_d;

   xspi_rr_arbiter #(
      .NREQ (NREQ),
      .IDX_W(IDX_W)
   ) u_arb (
      .valid(bus.req_valid),
      .ptr  (rr_ptr_q),
      .grant(grant),
      .idx  (win_idx)
   );

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      idx_d         = idx_q;
      cmd_d         = cmd_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      status_d      = status_q;
      retry_d       = retry_q;
      timer_d       = timer_q;
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      bus.eng_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            bus.req_ready = grant;
            if (|grant) begin
               idx_d   = win_idx;
               cmd_d   = cmd_of(bus.req_write[win_idx]);
               addr_d  = bus.req_addr[32'(win_idx) * 48 +: 48];
               wdata_d = bus.req_wdata[32'(win_idx) * 64 +: 64];
               retry_d = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (!bus.eng_busy) begin
               bus.eng_start = 1'b1;
               timer_d       = '0;
               state_d       = StWait;
            end
         end
         StWait: begin
            timer_d = timer_q + 1'b1;
            // eng_done takes priority over a timeout landing in the same cycle
            if (bus.eng_done) begin
               if (!bus.eng_crc_err) begin
                  status_d = ST_OK;
                  rdata_d  = (cmd_q == CMD_READ) ? bus.eng_rdata : '0;
                  state_d  = StResp;
               end else if (retry_q < 3'(MAX_RETRY)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = StIssue;
               end else begin
                  status_d = ST_CRC_FAIL;
                  rdata_d  = '0;
                  state_d  = StResp;
               end
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               status_d = ST_TIMEOUT;
               rdata_d  = '0;
               state_d  = StResp;
            end
         end
         StResp: begin
            bus.rsp_valid[idx_q] = 1'b1;
            rr_ptr_d             = (32'(idx_q) == NREQ - 1) ? '0 : idx_q + 1'b1;
            state_d              = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         idx_q    <= '0;
         cmd_q    <= 8'h00;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         status_q <= ST_OK;
         retry_q  <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         idx_q    <= idx_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
         retry_q  <= retry_d;
         timer_q  <= timer_d;
      end
   end

   assign bus.eng_cmd    = cmd_q;
   assign bus.eng_addr   = addr_q;
   assign bus.eng_wdata  = wdata_q;
   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_status = status_q;
   assign retry_cnt      = retry_q;
   assign busy           = (state_q != StIdle);

endmodule
